// File: rtl/axi_mem_fifo_regmap.sv
// Register map with an event FIFO, overflow counter and config registers, behind a simple word-addressed memory port.
// Optional free-running TIMESTAMP counter enabled by defining REGMAP_TIMESTAMP_EN.
module axi_mem_fifo_regmap #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH     = 9,
  parameter int FIFO_DEPTH         = 16,
  parameter int NUM_CFG            = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  output logic [C_S_AXI_DATA_WIDTH-1:0] axi_mem_rdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] axi_mem_wdata,
  input  logic [MEM_ADDR_WIDTH-1:0]     axi_mem_rdAddr,
  input  logic [MEM_ADDR_WIDTH-1:0]     axi_mem_wrAddr,
  input  logic [3:0]                    axi_mem_wrByteStrobe,
  input  logic                          axi_mem_rdStrobe,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_CFG*32-1:0]         cfg_out,
  output logic                          enable,
  output logic                          irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [MEM_ADDR_WIDTH-1:0] A_CTRL    = MEM_ADDR_WIDTH'(0);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_STATUS  = MEM_ADDR_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_FIFO    = MEM_ADDR_WIDTH'(2);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_OVF     = MEM_ADDR_WIDTH'(3);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_TS      = MEM_ADDR_WIDTH'(4);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_CFG     = MEM_ADDR_WIDTH'(8);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_CFG_END = MEM_ADDR_WIDTH'(8 + NUM_CFG);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [1:0]               ctrl_r;
  logic [NUM_CFG-1:0][31:0] cfg_r;
  logic [31:0]              mem_r [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]            level_r;
  logic                     ovf_r, udf_r, irq_r;
  logic [31:0]              ovf_cnt_r;
  logic wr_en_s, clear_s, pop_req_s, pop_s, push_s, ovf_evt_s, empty_s, full_s;
  logic wr_cfg_s, rd_cfg_s;

  // Access decode and FIFO handshake, all from registered state
  always_comb begin
    wr_en_s   = |axi_mem_wrByteStrobe;
    empty_s   = (level_r == LW'(0));
    full_s    = (level_r == LW'(FIFO_DEPTH));
    clear_s   = wr_en_s && (axi_mem_wrAddr == A_CTRL) && axi_mem_wrByteStrobe[0] && axi_mem_wdata[2];
    pop_req_s = axi_mem_rdStrobe && (axi_mem_rdAddr == A_FIFO);
    pop_s     = pop_req_s && !empty_s;
    push_s    = in_valid && ctrl_r[0] && !full_s;
    ovf_evt_s = in_valid && ctrl_r[0] && full_s;
    wr_cfg_s  = wr_en_s && (axi_mem_wrAddr >= A_CFG) && (axi_mem_wrAddr < A_CFG_END);
    rd_cfg_s  = (axi_mem_rdAddr >= A_CFG) && (axi_mem_rdAddr < A_CFG_END);
  end

  assign in_ready = ctrl_r[0] & ~full_s;
  assign enable   = ctrl_r[0];
  assign irq      = irq_r;
  assign cfg_out  = cfg_r;

`ifdef REGMAP_TIMESTAMP_EN
  logic [31:0] ts_r;

  // Free-running cycle counter
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) ts_r <= 32'd0;
    else              ts_r <= ts_r + 32'd1;
  end
`endif

  // Control, config, overflow counter and interrupt registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_r    <= 2'b00;
      cfg_r     <= '0;
      ovf_cnt_r <= 32'd0;
      irq_r     <= 1'b0;
    end else begin
      if (wr_en_s && (axi_mem_wrAddr == A_CTRL) && axi_mem_wrByteStrobe[0])
        ctrl_r <= axi_mem_wdata[1:0];
      if (wr_cfg_s)
        cfg_r[axi_mem_wrAddr[2:0]] <= byte_merge(cfg_r[axi_mem_wrAddr[2:0]], axi_mem_wdata, axi_mem_wrByteStrobe);
      // A clearing write beats a concurrent overflow increment
      if (wr_en_s && (axi_mem_wrAddr == A_OVF))
        ovf_cnt_r <= 32'd0;
      else if (ovf_evt_s && (ovf_cnt_r != 32'hFFFF_FFFF))
        ovf_cnt_r <= ovf_cnt_r + 32'd1;
      irq_r <= ctrl_r[1] & (~empty_s | ovf_r);
    end
  end

  // FIFO pointers, level and sticky flags; fifo_clear wins over push and pop
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || clear_s) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      level_r  <= LW'(0);
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (ovf_evt_s) ovf_r <= 1'b1;
      if (pop_req_s && empty_s) udf_r <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge S_AXI_ACLK) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

  // Read mux; during reset only the reset view of the map is visible
  always_comb begin
    axi_mem_rdata = 32'd0;
    if (S_AXI_ARESET) begin
      if (axi_mem_rdAddr == A_STATUS) axi_mem_rdata = 32'h0001_0000;
      else                            axi_mem_rdata = 32'd0;
    end else begin
      case (axi_mem_rdAddr)
        A_CTRL:   axi_mem_rdata = {30'd0, ctrl_r};
        A_STATUS: axi_mem_rdata = {12'd0, udf_r, ovf_r, full_s, empty_s, 16'(level_r)};
        A_FIFO:   axi_mem_rdata = empty_s ? 32'd0 : mem_r[rd_ptr_r];
        A_OVF:    axi_mem_rdata = ovf_cnt_r;
`ifdef REGMAP_TIMESTAMP_EN
        A_TS:     axi_mem_rdata = ts_r;
`else
        A_TS:     axi_mem_rdata = 32'd0;
`endif
        default: begin
          if (rd_cfg_s) axi_mem_rdata = cfg_r[axi_mem_rdAddr[2:0]];
          else          axi_mem_rdata = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_fifo_regmap.sv
// Directed bench for axi_mem_fifo_regmap with a queue-based reference model checked every cycle.
module tb_axi_mem_fifo_regmap;
  localparam int DEPTH = 16;
  localparam int NCFG  = 8;

  logic                S_AXI_ACLK = 1'b0;
  logic                S_AXI_ARESET = 1'b1;
  logic [31:0]         axi_mem_rdata;
  logic [31:0]         axi_mem_wdata = 32'd0;
  logic [8:0]          axi_mem_rdAddr = 9'd0;
  logic [8:0]          axi_mem_wrAddr = 9'd0;
  logic [3:0]          axi_mem_wrByteStrobe = 4'd0;
  logic                axi_mem_rdStrobe = 1'b0;
  logic [31:0]         in_data = 32'd0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NCFG*32-1:0]  cfg_out;
  logic                enable;
  logic                irq;

  int checks = 0;
  int errors = 0;

  axi_mem_fifo_regmap #(.C_S_AXI_DATA_WIDTH(32), .MEM_ADDR_WIDTH(9), .FIFO_DEPTH(DEPTH), .NUM_CFG(NCFG)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET), .axi_mem_rdata(axi_mem_rdata),
    .axi_mem_wdata(axi_mem_wdata), .axi_mem_rdAddr(axi_mem_rdAddr), .axi_mem_wrAddr(axi_mem_wrAddr),
    .axi_mem_wrByteStrobe(axi_mem_wrByteStrobe), .axi_mem_rdStrobe(axi_mem_rdStrobe),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .cfg_out(cfg_out),
    .enable(enable), .irq(irq));

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // Reference model state
  logic [31:0] m_q[$];
  logic [1:0]  m_ctrl = 2'b00;
  logic [31:0] m_cfg[NCFG];
  logic        m_ovf = 1'b0, m_udf = 1'b0, m_irq = 1'b0;
  logic [31:0] m_ovfcnt = 32'd0, m_ts = 32'd0;
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [8:0] a);
    int n;
    n = m_q.size();
    if (S_AXI_ARESET) return (a == 9'd1) ? 32'h0001_0000 : 32'd0;
    case (a)
      9'd0: return {30'd0, m_ctrl};
      9'd1: return {12'd0, m_udf, m_ovf, n == DEPTH, n == 0, 16'(n)};
      9'd2: return (n == 0) ? 32'd0 : m_q[0];
      9'd3: return m_ovfcnt;
`ifdef REGMAP_TIMESTAMP_EN
      9'd4: return m_ts;
`else
      9'd4: return 32'd0;
`endif
      default: return (a >= 9'd8 && a < 9'(8 + NCFG)) ? m_cfg[a - 9'd8] : 32'd0;
    endcase
  endfunction

  // Model update at each rising edge from the inputs held stable across it
  always @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      m_q.delete(); m_ctrl = 2'b00; m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
      m_ovfcnt = 32'd0; m_ts = 32'd0; model_ok = 1'b1;
      for (int k = 0; k < NCFG; k++) m_cfg[k] = 32'd0;
    end else begin
      bit full, empty, wr, clr, preq, ovf_evt, do_push;
      full = (m_q.size() == DEPTH); empty = (m_q.size() == 0);
      wr = (axi_mem_wrByteStrobe != 4'd0);
      clr = wr && axi_mem_wrAddr == 9'd0 && axi_mem_wrByteStrobe[0] && axi_mem_wdata[2];
      preq = axi_mem_rdStrobe && axi_mem_rdAddr == 9'd2;
      ovf_evt = in_valid && m_ctrl[0] && full;
      do_push = in_valid && m_ctrl[0] && !full;
      m_irq = m_ctrl[1] && (!empty || m_ovf);
      if (wr && axi_mem_wrAddr == 9'd3) m_ovfcnt = 32'd0;
      else if (ovf_evt && m_ovfcnt != 32'hFFFF_FFFF) m_ovfcnt = m_ovfcnt + 32'd1;
      if (clr) begin
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
        if (preq && !empty) void'(m_q.pop_front());
        if (preq && empty) m_udf = 1'b1;
        if (do_push) m_q.push_back(in_data);
        if (ovf_evt) m_ovf = 1'b1;
      end
      if (wr && axi_mem_wrAddr == 9'd0 && axi_mem_wrByteStrobe[0]) m_ctrl = axi_mem_wdata[1:0];
      if (wr && axi_mem_wrAddr >= 9'd8 && axi_mem_wrAddr < 9'(8 + NCFG))
        for (int b = 0; b < 4; b++)
          if (axi_mem_wrByteStrobe[b]) m_cfg[axi_mem_wrAddr - 9'd8][8*b +: 8] = axi_mem_wdata[8*b +: 8];
      m_ts = m_ts + 32'd1;
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge S_AXI_ACLK) begin
    if (model_ok) begin
      chk("rdata", axi_mem_rdata, exp_rdata(axi_mem_rdAddr));
      chk("ready_en_irq", {29'd0, in_ready, enable, irq},
          {29'd0, m_ctrl[0] && (m_q.size() != DEPTH), m_ctrl[0], m_irq});
      for (int k = 0; k < NCFG; k++) chk("cfg_out", cfg_out[32*k +: 32], m_cfg[k]);
    end
  end

  task automatic tick();
    @(posedge S_AXI_ACLK); #2;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_mem_wrAddr = a; axi_mem_wdata = d; axi_mem_wrByteStrobe = s;
    tick();
    axi_mem_wrByteStrobe = 4'd0;
  endtask

  task automatic rd_chk(input string name, input logic [8:0] a, input logic [31:0] exp);
    axi_mem_rdAddr = a; #1;
    chk(name, axi_mem_rdata, exp);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = 32'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input logic [31:0] exp);
    axi_mem_rdAddr = 9'd2; axi_mem_rdStrobe = 1'b1; #1;
    chk("pop_data", axi_mem_rdata, exp);
    tick();
    axi_mem_rdStrobe = 1'b0;
  endtask

  logic [31:0] t0, t1;

  initial begin
    tick(); tick();
    rd_chk("status_in_reset", 9'd1, 32'h0001_0000);
    tick();
    S_AXI_ARESET = 1'b0;
    tick();
    rd_chk("ctrl_reset", 9'd0, 32'd0);
    rd_chk("status_reset", 9'd1, 32'h0001_0000);
    rd_chk("cfg0_reset", 9'd8, 32'd0);
    chk("in_ready_reset", {31'd0, in_ready}, 32'd0);
    tick();

    wr(9'd10, 32'hA5A5_A5A5, 4'b0101);
    rd_chk("cfg2_strobe", 9'd10, 32'h00A5_00A5);
    chk("cfg_out_cfg2", cfg_out[95:64], 32'h00A5_00A5);
    wr(9'd1, 32'hFFFF_FFFF, 4'hF);
    rd_chk("status_write_ignored", 9'd1, 32'h0001_0000);
    wr(9'd5, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_zero", 9'd5, 32'd0);
    push_n(1, 7);
    rd_chk("disabled_no_push", 9'd1, 32'h0001_0000);
    rd_chk("disabled_no_ovf", 9'd3, 32'd0);

    wr(9'd0, 32'd1, 4'b0001);
    push_n(16, 1);
    push_n(1, 17);
    rd_chk("status_full_ovf", 9'd1, 32'h0006_0010);
    rd_chk("ovf_count_1", 9'd3, 32'd1);
    chk("in_ready_full", {31'd0, in_ready}, 32'd0);

    for (int i = 1; i <= 17; i++) pop_chk((i <= 16) ? 32'(i) : 32'd0);
    rd_chk("status_underflow", 9'd1, 32'h000D_0000);

    push_n(5, 101);
    in_valid = 1'b1; in_data = 32'd106;
    axi_mem_rdAddr = 9'd2; axi_mem_rdStrobe = 1'b1; #1;
    chk("pushpop_head", axi_mem_rdata, 32'd101);
    tick();
    in_valid = 1'b0; axi_mem_rdStrobe = 1'b0;
    rd_chk("status_level5", 9'd1, 32'h000C_0005);
    wr(9'd0, 32'd3, 4'b0001);
    tick(); #1;
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(9'd0, 32'd5, 4'b0001);
    rd_chk("status_cleared", 9'd1, 32'h0001_0000);
    rd_chk("ovf_after_clear", 9'd3, 32'd1);
    wr(9'd3, 32'd0, 4'b1000);
    rd_chk("ovf_write_clear", 9'd3, 32'd0);

    axi_mem_rdAddr = 9'd4; #1; t0 = axi_mem_rdata;
    repeat (10) tick();
    #1; t1 = axi_mem_rdata;
`ifdef REGMAP_TIMESTAMP_EN
    chk("ts_diff", t1 - t0, 32'd10);
`else
    chk("ts_read0", t0, 32'd0);
    chk("ts_read1", t1, 32'd0);
`endif
    tick();

    push_n(16, 200);
    axi_mem_wrAddr = 9'd3; axi_mem_wdata = 32'd0; axi_mem_wrByteStrobe = 4'b0001;
    in_valid = 1'b1; in_data = 32'd999;
    tick();
    axi_mem_wrByteStrobe = 4'd0; in_valid = 1'b0;
    rd_chk("ovf_write_vs_event", 9'd3, 32'd0);
    rd_chk("status_full_again", 9'd1, 32'h0006_0010);

    in_valid = 1'b1; axi_mem_wrAddr = 9'd8; axi_mem_wdata = 32'hFFFF_FFFF; axi_mem_wrByteStrobe = 4'hF;
    S_AXI_ARESET = 1'b1;
    tick();
    in_valid = 1'b0; axi_mem_wrByteStrobe = 4'd0;
    rd_chk("status_mid_reset", 9'd1, 32'h0001_0000);
    tick();
    S_AXI_ARESET = 1'b0;
    tick();
    rd_chk("ctrl_after_reset", 9'd0, 32'd0);
    rd_chk("cfg0_after_reset", 9'd8, 32'd0);
    rd_chk("status_after_reset", 9'd1, 32'h0001_0000);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
